// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate-select codes and the
// decoded bundle that travels from decode towards execute.
package rv32_pkg;

  localparam int PC_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] IMM_SEL_U20 = 2'b00;
  localparam logic [1:0] IMM_SEL_A12 = 2'b01;
  localparam logic [1:0] IMM_SEL_B12 = 2'b10;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm20;
    logic [11:0] imm12a;
    logic [11:0] imm12b;
    logic [1:0]  imm_sel;
    logic        illegal;
  } id_fields_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    id_fields_t      f;
  } id_bundle_t;

endpackage

// File: rtl/inst_field_decode.sv
// Purely combinational RV32I field extraction and immediate-select decode.
module inst_field_decode
  import rv32_pkg::*;
(
  input  logic [31:0] inst,
  output id_fields_t  fields
);

  always_comb begin
    fields         = '0;
    fields.opcode  = inst[6:0];
    fields.rd      = inst[11:7];
    fields.rs1     = inst[19:15];
    fields.rs2     = inst[24:20];
    fields.funct3  = inst[14:12];
    fields.funct7  = inst[31:25];
    fields.imm20   = inst[31:12];
    fields.imm12a  = inst[31:20];
    fields.imm12b  = '0;
    fields.imm_sel = IMM_SEL_U20;
    fields.illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fields.imm_sel = IMM_SEL_A12;
      OPC_STORE: begin
        fields.imm_sel = IMM_SEL_B12;
        fields.imm12b  = {inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fields.imm_sel = IMM_SEL_B12;
        fields.imm12b  = {inst[31], inst[7], inst[30:25], inst[11:8]};
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_FENCE, OPC_SYSTEM:
        fields.imm_sel = IMM_SEL_U20;
      default: fields.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF->ID pipeline stage: decodes the fetched instruction and registers the
// bundle towards execute, with a one-entry skid buffer absorbing stalls.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [19:0]       imm20_o,
  output logic [11:0]       imm12a_o,
  output logic [11:0]       imm12b_o,
  output logic [1:0]        imm_sel_o,
  output logic              illegal_o
);

  id_fields_t dec_fields;
  id_bundle_t dec_bundle;
  id_bundle_t main_q;
  id_bundle_t skid_q;
  logic       main_valid;
  logic       skid_valid;
  logic       in_fire;
  logic       out_fire;

  inst_field_decode u_dec (
    .inst   (if_inst_i),
    .fields (dec_fields)
  );

  assign dec_bundle = '{pc: if_pc_i, f: dec_fields};

  // Ready comes only from the skid flop, so it never sees ex_ready_i.
  assign if_ready_o = ~skid_valid;
  assign in_fire    = if_valid_i & if_ready_o;
  assign out_fire   = main_valid & ex_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid || out_fire) begin
        main_q     <= dec_bundle;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec_bundle;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign ex_valid_o = main_valid;
  assign pc_o       = main_q.pc;
  assign opcode_o   = main_q.f.opcode;
  assign rd_o       = main_q.f.rd;
  assign rs1_o      = main_q.f.rs1;
  assign rs2_o      = main_q.f.rs2;
  assign funct3_o   = main_q.f.funct3;
  assign funct7_o   = main_q.f.funct7;
  assign imm20_o    = main_q.f.imm20;
  assign imm12a_o   = main_q.f.imm12a;
  assign imm12b_o   = main_q.f.imm12b;
  assign imm_sel_o  = main_q.f.imm_sel;
  assign illegal_o  = main_q.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hand-written
// backpressure, throughput, flush and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, ex_valid, ex_ready;
  logic [31:0] if_pc, if_inst, pc;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [19:0] imm20;
  logic [11:0] imm12a, imm12b;
  logic [1:0]  imm_sel;
  logic        illegal;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  decode_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(if_ready),
    .if_pc_i(if_pc), .if_inst_i(if_inst),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .pc_o(pc), .opcode_o(opcode), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .funct3_o(funct3), .funct7_o(funct7), .imm20_o(imm20),
    .imm12a_o(imm12a), .imm12b_o(imm12b), .imm_sel_o(imm_sel),
    .illegal_o(illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [19:0] imm20;
    logic [11:0] imm12a, imm12b;
    logic [1:0]  sel;
    logic        ill;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i);
    if_valid = v;
    if_pc    = p;
    if_inst  = i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //            pc        inst          opc    rd     rs1    rs2    f3    f7     imm20     imm12a  imm12b  sel    ill
    vecs[0] = '{32'h100, 32'hFFF00093, 7'h13, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 20'hFFF00, 12'hFFF, 12'h000, 2'b01, 1'b0};
    vecs[1] = '{32'h104, 32'h0020A423, 7'h23, 5'd8,  5'd1, 5'd2,  3'd2, 7'h00, 20'h0020A, 12'h002, 12'h008, 2'b10, 1'b0};
    vecs[2] = '{32'h108, 32'h123452B7, 7'h37, 5'd5,  5'd8, 5'd3,  3'd5, 7'h09, 20'h12345, 12'h123, 12'h000, 2'b00, 1'b0};
    vecs[3] = '{32'h10C, 32'hFE208EE3, 7'h63, 5'd29, 5'd1, 5'd2,  3'd0, 7'h7F, 20'hFE208, 12'hFE2, 12'hFFE, 2'b10, 1'b0};
    vecs[4] = '{32'h110, 32'h0000007F, 7'h7F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 20'h00000, 12'h000, 12'h000, 2'b00, 1'b1};
    vecs[5] = '{32'h114, 32'h00412183, 7'h03, 5'd3,  5'd2, 5'd4,  3'd2, 7'h00, 20'h00412, 12'h004, 12'h000, 2'b01, 1'b0};
    vecs[6] = '{32'h118, 32'h0000006F, 7'h6F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 20'h00000, 12'h000, 12'h000, 2'b00, 1'b0};

    flush    = 1'b0;
    ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    do_reset();

    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset if_ready", {31'd0, if_ready}, 32'd1);
    chk("reset pc",       pc, 32'd0);
    chk("reset imm12a",   {20'd0, imm12a}, 32'd0);

    // Decode table: one instruction per cycle, ex_ready held high.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, vecs[k].pc, vecs[k].inst);
      tick();
      chk("vec ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("vec pc",       pc, vecs[k].pc);
      chk("vec opcode",   {25'd0, opcode}, {25'd0, vecs[k].opc});
      chk("vec rd",       {27'd0, rd},  {27'd0, vecs[k].rd});
      chk("vec rs1",      {27'd0, rs1}, {27'd0, vecs[k].rs1});
      chk("vec rs2",      {27'd0, rs2}, {27'd0, vecs[k].rs2});
      chk("vec funct3",   {29'd0, funct3}, {29'd0, vecs[k].f3});
      chk("vec funct7",   {25'd0, funct7}, {25'd0, vecs[k].f7});
      chk("vec imm20",    {12'd0, imm20},  {12'd0, vecs[k].imm20});
      chk("vec imm12a",   {20'd0, imm12a}, {20'd0, vecs[k].imm12a});
      chk("vec imm12b",   {20'd0, imm12b}, {20'd0, vecs[k].imm12b});
      chk("vec imm_sel",  {30'd0, imm_sel}, {30'd0, vecs[k].sel});
      chk("vec illegal",  {31'd0, illegal}, {31'd0, vecs[k].ill});
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain ex_valid", {31'd0, ex_valid}, 32'd0);

    // Backpressure: A, B, C back-to-back with execute stalled for 3 cycles.
    ex_ready = 1'b0;
    drive(1'b1, 32'hA00, vecs[0].inst);
    tick();
    chk("bp A ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("bp A pc",       pc, 32'hA00);
    chk("bp A if_ready", {31'd0, if_ready}, 32'd1);
    drive(1'b1, 32'hB00, vecs[1].inst);
    tick();
    chk("bp B pc held",  pc, 32'hA00);
    chk("bp B if_ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'hC00, vecs[2].inst);
    tick();
    chk("bp C pc held",    pc, 32'hA00);
    chk("bp C opcode held", {25'd0, opcode}, 32'h13);
    chk("bp C if_ready",   {31'd0, if_ready}, 32'd0);
    ex_ready = 1'b1;
    tick();
    chk("bp out B pc",     pc, 32'hB00);
    chk("bp out B opcode", {25'd0, opcode}, 32'h23);
    chk("bp out B ready",  {31'd0, if_ready}, 32'd1);
    tick();
    chk("bp out C pc",     pc, 32'hC00);
    chk("bp out C valid",  {31'd0, ex_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp end ex_valid", {31'd0, ex_valid}, 32'd0);

    // Throughput stream with scoreboard: one bundle out per cycle, in order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), vecs[k].inst);
      exp_q.push_back(32'h200 + 32'(4 * k));
      tick();
      if (ex_valid) chk("stream pc", pc, exp_q.pop_front());
    end
    drive(1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ex_valid) begin
        if (exp_q.size() == 0) chk("stream extra output", pc, 32'hFFFF_FFFF);
        else chk("stream pc", pc, exp_q.pop_front());
      end
    end
    chk("stream leftover", exp_q.size(), 32'd0);
    exp_q.delete();

    // Flush with main and skid full and a further input presented.
    ex_ready = 1'b0;
    drive(1'b1, 32'h300, vecs[0].inst);
    tick();
    drive(1'b1, 32'h304, vecs[1].inst);
    tick();
    chk("fl full ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'h308, vecs[2].inst);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl if_ready", {31'd0, if_ready}, 32'd1);
    // Flush also discards an input that fires in the same cycle.
    drive(1'b1, 32'h30C, vecs[3].inst);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl same-cycle ex_valid", {31'd0, ex_valid}, 32'd0);
    ex_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl nothing emerges", {31'd0, ex_valid}, 32'd0);
    end

    // Reset during backpressure.
    ex_ready = 1'b0;
    drive(1'b1, 32'h400, vecs[0].inst);
    tick();
    drive(1'b1, 32'h404, vecs[1].inst);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst bp ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst bp if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst bp pc",       pc, 32'd0);
    chk("rst bp imm12a",   {20'd0, imm12a}, 32'd0);
    chk("rst bp imm_sel",  {30'd0, imm_sel}, 32'd0);
    ex_ready = 1'b1;
    tick();
    chk("rst bp no skid leak", {31'd0, ex_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
